// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style control FSM with memory-wait timeout and trap.
// Outputs are decoded from state; only fetch/store completion looks at mem_ready.
module mc_control_fsm #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4,
    parameter bit EN_NORI = 1'b1,
    parameter bit EN_JUMP = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdest,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsource,
    output logic [3:0] state,
    output logic       done,
    output logic       illegal,
    output logic       bus_err
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } t_state;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_NORI = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [CNT_W-1:0] LP_TLAST = CNT_W'(TIMEOUT - 1);

    t_state             r_state;
    t_state             w_next;
    logic [CNT_W-1:0]   r_wcnt;
    logic               r_bus_err;
    logic               w_mem_st;
    logic               w_tmo;

    assign w_mem_st = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                      (r_state == S_MEMWR);
    // mem_ready in the last allowed cycle still completes normally
    assign w_tmo = (TIMEOUT != 0) && (r_wcnt == LP_TLAST) && !mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_wcnt    <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wcnt <= '0;
            else if (w_mem_st && !mem_ready)
                r_wcnt <= r_wcnt + 1'b1;
            if (w_next == S_TRAP)
                r_bus_err <= 1'b1;
        end
    end

    always_comb begin
        w_next      = S_FETCH;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdest     = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
        pcsource    = 2'b00;
        done        = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
                if (mem_ready)  w_next = S_DECODE;
                else if (w_tmo) w_next = S_TRAP;
                else            w_next = S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                unique case (1'b1)
                    (op == OP_LW),
                    (op == OP_SW):              w_next = S_MEMADR;
                    (op == OP_R):               w_next = S_EXEC;
                    (op == OP_BEQ):             w_next = S_BRANCH;
                    (op == OP_NORI && EN_NORI): w_next = S_IEXEC;
                    (op == OP_J && EN_JUMP):    w_next = S_JUMP;
                    default: begin
                        w_next  = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (mem_ready)  w_next = S_MEMWB;
                else if (w_tmo) w_next = S_TRAP;
                else            w_next = S_MEMRD;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                done     = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                done     = mem_ready;
                if (mem_ready)  w_next = S_FETCH;
                else if (w_tmo) w_next = S_TRAP;
                else            w_next = S_MEMWR;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                w_next  = S_RWB;
            end
            S_RWB: begin
                regdest  = 1'b1;
                regwrite = 1'b1;
                done     = 1'b1;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
                done        = 1'b1;
            end
            S_IEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 2'b11;
                w_next  = S_IWB;
            end
            S_IWB: begin
                regwrite = 1'b1;
                done     = 1'b1;
            end
            S_JUMP: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
                done     = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign state   = r_state;
    assign bus_err = r_bus_err;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: default build plus a build
// with nori and j disabled, driven from the same inputs.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       mem_ready;

    logic       a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst;
    logic       a_rw, a_asa, a_done, a_ill, a_berr;
    logic [1:0] a_asb, a_aop, a_pcs;
    logic [3:0] a_st;

    logic       b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst;
    logic       b_rw, b_asa, b_done, b_ill, b_berr;
    logic [1:0] b_asb, b_aop, b_pcs;
    logic [3:0] b_st;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mc_control_fsm u_dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pcwrite(a_pcw), .pcwritecond(a_pcwc), .iord(a_iord),
        .memread(a_mrd), .memwrite(a_mwr), .irwrite(a_irw),
        .memtoreg(a_m2r), .regdest(a_rdst), .regwrite(a_rw),
        .alusrca(a_asa), .alusrcb(a_asb), .aluop(a_aop),
        .pcsource(a_pcs), .state(a_st), .done(a_done),
        .illegal(a_ill), .bus_err(a_berr)
    );

    mc_control_fsm #(.EN_NORI(1'b0), .EN_JUMP(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pcwrite(b_pcw), .pcwritecond(b_pcwc), .iord(b_iord),
        .memread(b_mrd), .memwrite(b_mwr), .irwrite(b_irw),
        .memtoreg(b_m2r), .regdest(b_rdst), .regwrite(b_rw),
        .alusrca(b_asa), .alusrcb(b_asb), .aluop(b_aop),
        .pcsource(b_pcs), .state(b_st), .done(b_done),
        .illegal(b_ill), .bus_err(b_berr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] o, input logic r);
        op        = o;
        mem_ready = r;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(6'b000000, 1'b0);
        chk("rst_state", a_st, 0);
        chk("rst_berr", a_berr, 0);
        chk("rst_memread", a_mrd, 1);
        chk("rst_irwrite", a_irw, 0);
        tick();
        rst_n = 1'b1;

        // lw, memory always ready
        drive(6'b100011, 1'b1);
        chk("lw_s0", a_st, 0);
        chk("lw_irw", {a_irw, a_pcw, a_asb}, {1'b1, 1'b1, 2'b01});
        tick();
        chk("lw_s1", {a_st, a_asb, a_done}, {4'd1, 2'b11, 1'b0});
        tick();
        chk("lw_s2", {a_st, a_asa, a_asb, a_done}, {4'd2, 1'b1, 2'b10, 1'b0});
        tick();
        chk("lw_s3", {a_st, a_mrd, a_iord, a_done}, {4'd3, 1'b1, 1'b1, 1'b0});
        tick();
        chk("lw_s4", {a_st, a_rw, a_m2r, a_rdst, a_done},
            {4'd4, 1'b1, 1'b1, 1'b0, 1'b1});
        tick();
        chk("lw_end", {a_st, a_done}, {4'd0, 1'b0});

        // R-format, fetch waits three cycles
        drive(6'b000000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("r_fwait", {a_st, a_irw, a_pcw}, {4'd0, 1'b0, 1'b0});
            tick();
        end
        drive(6'b000000, 1'b1);
        chk("r_f4", {a_st, a_irw, a_pcw}, {4'd0, 1'b1, 1'b1});
        tick();
        chk("r_s1", a_st, 1);
        tick();
        chk("r_s6", {a_st, a_asa, a_asb, a_aop, a_rw}, {4'd6, 1'b1, 2'b00, 2'b10, 1'b0});
        tick();
        chk("r_s7", {a_st, a_rdst, a_rw, a_done}, {4'd7, 1'b1, 1'b1, 1'b1});
        tick();
        chk("r_end", a_st, 0);

        // lw, read completes on the last allowed wait cycle
        drive(6'b100011, 1'b1);
        tick();
        tick();
        drive(6'b100011, 1'b0);
        tick();
        for (int i = 0; i < 14; i++) begin
            chk("bnd_wait", a_st, 3);
            tick();
        end
        drive(6'b100011, 1'b1);
        chk("bnd_last", a_st, 3);
        tick();
        chk("bnd_exit", {a_st, a_berr}, {4'd4, 1'b0});
        tick();
        chk("bnd_end", {a_st, a_berr}, {4'd0, 1'b0});

        // sw, memory never ready: timeout into TRAP
        drive(6'b101011, 1'b1);
        tick();
        tick();
        drive(6'b101011, 1'b0);
        tick();
        for (int i = 0; i < 15; i++) begin
            chk("sw_wait", {a_st, a_mwr, a_mrd, a_done, a_berr},
                {4'd5, 1'b1, 1'b0, 1'b0, 1'b0});
            tick();
        end
        chk("sw_trap", {a_st, a_berr, a_mwr, a_mrd, a_rw, a_pcw},
            {4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        drive(6'b101011, 1'b1);
        tick();
        chk("sw_after", {a_st, a_berr}, {4'd0, 1'b1});

        // illegal opcode on both builds
        drive(6'b111111, 1'b1);
        tick();
        chk("ill_dec", {a_st, a_ill, a_rw, a_mwr, a_pcw}, {4'd1, 1'b1, 3'b000});
        chk("ill_dec2", {b_st, b_ill}, {4'd1, 1'b1});
        tick();
        chk("ill_end", {a_st, a_ill, b_st}, {4'd0, 1'b0, 4'd0});

        // nori: legal on default build, illegal with EN_NORI=0
        drive(6'b001101, 1'b1);
        tick();
        chk("nori_dec", {a_ill, b_ill, b_rw, b_mwr}, 4'b0100);
        drive(6'b001101, 1'b0);
        tick();
        chk("nori_ex", {a_st, a_asa, a_asb, a_aop}, {4'd9, 1'b1, 2'b10, 2'b11});
        chk("nori_b", {b_st, b_rw, b_mwr}, {4'd0, 2'b00});
        tick();
        chk("nori_wb", {a_st, a_rw, a_rdst, a_done}, {4'd10, 3'b101});
        tick();
        chk("nori_end", a_st, 0);

        // j: legal on default build, illegal with EN_JUMP=0
        drive(6'b000010, 1'b1);
        tick();
        chk("j_dec", {a_ill, b_ill}, 2'b01);
        drive(6'b000010, 1'b0);
        tick();
        chk("j_jump", {a_st, a_pcw, a_pcs, a_done}, {4'd11, 1'b1, 2'b10, 1'b1});
        chk("j_b", b_st, 0);
        tick();
        chk("j_end", a_st, 0);

        // async reset in the middle of a read wait with bus_err set
        drive(6'b100011, 1'b1);
        tick();
        tick();
        drive(6'b100011, 1'b0);
        tick();
        tick();
        chk("ar_pre", {a_st, a_berr}, {4'd3, 1'b1});
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_now", {a_st, a_berr, a_mrd, a_iord}, {4'd0, 1'b0, 1'b1, 1'b0});
        tick();
        chk("ar_hold", a_st, 0);
        rst_n = 1'b1;
        drive(6'b000100, 1'b1);
        chk("beq_s0", {a_st, a_irw}, {4'd0, 1'b1});
        tick();
        chk("beq_s1", a_st, 1);
        tick();
        chk("beq_s8", {a_st, a_pcwc, a_pcs, a_aop, a_asa, a_done},
            {4'd8, 1'b1, 2'b01, 2'b01, 1'b1, 1'b1});
        tick();
        chk("beq_end", {a_st, a_berr}, {4'd0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
